// File: rtl/pipe_ctrl_if.sv
// Interface between the pipeline controller and the core datapath.
// The core drives the hazard requests; the controller returns valids, enables, bubbles and counters.
interface pipe_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_WIDTH  = 32
);
  logic                  fetch_vld_i;
  logic [NUM_STAGES-1:0] stg_hold_i;
  logic                  load_use_i;
  logic                  br_taken_i;
  logic                  cnt_clr_i;
  logic [NUM_STAGES-1:0] stg_vld_o;
  logic [NUM_STAGES-1:0] stg_en_o;
  logic [NUM_STAGES-1:0] stg_clr_o;
  logic                  flush_o;
  logic                  retire_o;
  logic [CNT_WIDTH-1:0]  instret_o;
  logic [CNT_WIDTH-1:0]  stall_cnt_o;

  modport master (
    output fetch_vld_i, stg_hold_i, load_use_i, br_taken_i, cnt_clr_i,
    input  stg_vld_o, stg_en_o, stg_clr_o, flush_o, retire_o, instret_o, stall_cnt_o
  );

  modport slave (
    input  fetch_vld_i, stg_hold_i, load_use_i, br_taken_i, cnt_clr_i,
    output stg_vld_o, stg_en_o, stg_clr_o, flush_o, retire_o, instret_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush control for the in-order pipeline: per-stage valid tracking, register
// load-enables and bubble insertion, plus retired-instruction and front-end stall counters.
module pipe_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int ID_STAGE   = 1,
  parameter int BR_STAGE   = 2,
  parameter int CNT_WIDTH  = 32
) (
  input logic       clk,
  input logic       arst_n,
  pipe_ctrl_if.slave bus
);

  if (NUM_STAGES < 3) begin : g_bad_num_stages
    $error("pipe_ctrl: NUM_STAGES must be >= 3");
  end
  if (ID_STAGE < 1 || ID_STAGE >= BR_STAGE) begin : g_bad_id_stage
    $error("pipe_ctrl: ID_STAGE must satisfy 1 <= ID_STAGE < BR_STAGE");
  end
  if (BR_STAGE >= NUM_STAGES - 1) begin : g_bad_br_stage
    $error("pipe_ctrl: BR_STAGE must be < NUM_STAGES-1");
  end

  logic [NUM_STAGES-1:1] vld_q;
  logic [NUM_STAGES-1:0] vld;
  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] en;
  logic [NUM_STAGES-1:0] clr;
  logic                  flush;
  logic                  retire;
  logic [CNT_WIDTH-1:0]  instret_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;

  assign vld = {vld_q, bus.fetch_vld_i};

  always_comb begin
    hold           = bus.stg_hold_i;
    hold[ID_STAGE] = bus.stg_hold_i[ID_STAGE] | bus.load_use_i;
  end

  // A stage is frozen when it, or anything older than it, holds.
  always_comb begin
    stall                 = '0;
    stall[NUM_STAGES-1]   = hold[NUM_STAGES-1];
    for (int k = NUM_STAGES - 2; k >= 0; k--) begin
      stall[k] = hold[k] | stall[k+1];
    end
  end

  assign flush = bus.br_taken_i & vld[BR_STAGE] & ~stall[BR_STAGE];

  always_comb begin
    en  = '0;
    clr = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      en[k] = ~stall[k] | (flush & (k <= BR_STAGE));
    end
    for (int k = 1; k < NUM_STAGES; k++) begin
      clr[k] = (flush & (k <= BR_STAGE)) | (stall[k-1] & ~stall[k]);
    end
  end

  assign retire = vld[NUM_STAGES-1] & ~hold[NUM_STAGES-1];

  // Bubble insertion wins over a simultaneous load.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_q <= '0;
    end else begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (clr[k]) begin
          vld_q[k] <= 1'b0;
        end else if (en[k]) begin
          vld_q[k] <= vld[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      instret_q   <= '0;
      stall_cnt_q <= '0;
    end else if (bus.cnt_clr_i) begin
      instret_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (retire) begin
        instret_q <= instret_q + CNT_WIDTH'(1);
      end
      if (stall[0] & ~flush) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.stg_vld_o   = vld;
  assign bus.stg_en_o    = en;
  assign bus.stg_clr_o   = clr;
  assign bus.flush_o     = flush;
  assign bus.retire_o    = retire;
  assign bus.instret_o   = instret_q;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random hazards against a stage-occupancy model;
// a second instance with 4-bit counters shadows the same stimulus to exercise wrap-around.
module tb_pipe_ctrl;
  localparam int NS = 5;
  localparam int ID = 1;
  localparam int BR = 2;

  logic clk;
  logic arst_n;

  pipe_ctrl_if #(.NUM_STAGES(NS), .CNT_WIDTH(32)) bus ();
  pipe_ctrl_if #(.NUM_STAGES(NS), .CNT_WIDTH(4))  bus4 ();

  pipe_ctrl #(.NUM_STAGES(NS), .ID_STAGE(ID), .BR_STAGE(BR), .CNT_WIDTH(32)) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus)
  );
  pipe_ctrl #(.NUM_STAGES(NS), .ID_STAGE(ID), .BR_STAGE(BR), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .arst_n(arst_n), .bus(bus4)
  );

  assign bus4.fetch_vld_i = bus.fetch_vld_i;
  assign bus4.stg_hold_i  = bus.stg_hold_i;
  assign bus4.load_use_i  = bus.load_use_i;
  assign bus4.br_taken_i  = bus.br_taken_i;
  assign bus4.cnt_clr_i   = bus.cnt_clr_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model state: occupancy of stages 1..NS-1 and the two counters.
  logic [NS-1:0] mv;
  logic [31:0]   m_inst;
  logic [31:0]   m_stall;

  logic          fv, lu, br, cc;
  logic [NS-1:0] hd;

  logic [NS-1:0] e_vld, e_en, e_clr;
  logic          e_flush, e_ret;
  int            h;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic f, input logic [NS-1:0] hh, input logic l,
                        input logic b, input logic c);
    fv = f; hd = hh; lu = l; br = b; cc = c;
    bus.fetch_vld_i = f;
    bus.stg_hold_i  = hh;
    bus.load_use_i  = l;
    bus.br_taken_i  = b;
    bus.cnt_clr_i   = c;
  endtask

  task automatic model_reset();
    mv = '0; m_inst = '0; m_stall = '0;
  endtask

  // h = oldest stage that wants to hold (-1 if none); everything at or below h is frozen.
  task automatic model_comb();
    h = -1;
    for (int k = 0; k < NS; k++) if (hd[k] || (k == ID && lu)) h = k;
    e_vld   = {mv[NS-1:1], fv};
    e_flush = br && e_vld[BR] && (h < BR);
    for (int k = 0; k < NS; k++) begin
      e_en[k]  = (k > h) || (e_flush && k <= BR);
      e_clr[k] = (k >= 1) && ((e_flush && k <= BR) || k == h + 1);
    end
    e_ret = mv[NS-1] && !hd[NS-1];
  endtask

  // Stages above the frozen block shift up, the one just above it takes a bubble,
  // and a flush wipes the younger stages up to the branch.
  task automatic model_tick();
    logic [NS-1:0] nv;
    nv = mv;
    for (int k = 1; k < NS; k++) begin
      if (k <= h)          nv[k] = mv[k];
      else if (k == h + 1) nv[k] = 1'b0;
      else                 nv[k] = e_vld[k-1];
    end
    if (e_flush) for (int k = 1; k <= BR; k++) nv[k] = 1'b0;
    mv = nv;
    if (cc) begin
      m_inst = '0; m_stall = '0;
    end else begin
      if (e_ret) m_inst = m_inst + 1;
      if (h >= 0 && !e_flush) m_stall = m_stall + 1;
    end
  endtask

  task automatic check_all();
    chk("stg_vld",   64'(bus.stg_vld_o),    64'(e_vld));
    chk("stg_en",    64'(bus.stg_en_o),     64'(e_en));
    chk("stg_clr",   64'(bus.stg_clr_o),    64'(e_clr));
    chk("flush",     64'(bus.flush_o),      64'(e_flush));
    chk("retire",    64'(bus.retire_o),     64'(e_ret));
    chk("instret",   64'(bus.instret_o),    64'(m_inst));
    chk("stall_cnt", 64'(bus.stall_cnt_o),  64'(m_stall));
    chk("w4_vld",    64'({bus4.stg_vld_o, bus4.stg_en_o, bus4.stg_clr_o, bus4.flush_o, bus4.retire_o}),
                     64'({e_vld, e_en, e_clr, e_flush, e_ret}));
    chk("w4_instret", 64'(bus4.instret_o),   64'(m_inst[3:0]));
    chk("w4_stall",   64'(bus4.stall_cnt_o), 64'(m_stall[3:0]));
  endtask

  task automatic drive(input logic f, input logic [NS-1:0] hh, input logic l,
                       input logic b, input logic c);
    @(negedge clk);
    set_in(f, hh, l, b, c);
    #1;
    model_comb();
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    if (arst_n) model_tick();
  endtask

  task automatic step(input logic f, input logic [NS-1:0] hh, input logic l,
                      input logic b, input logic c);
    drive(f, hh, l, b, c);
    tick();
  endtask

  logic [NS-1:0] lit;
  logic [31:0]   saved;

  initial begin
    arst_n = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    model_comb();
    check_all();
    chk("rst_vld_lit", 64'(bus.stg_vld_o), 64'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // Fill from empty.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
      lit = (i < 5) ? NS'((32'd1 << (i + 1)) - 1) : 5'b11111;
      chk("fill_vld_lit", 64'(bus.stg_vld_o), 64'(lit));
      chk("fill_en_lit",  64'(bus.stg_en_o),  64'(5'b11111));
      chk("fill_clr_lit", 64'(bus.stg_clr_o), 64'd0);
      chk("fill_ret_lit", 64'(bus.retire_o),  64'(i >= 4));
      chk("fill_inst_lit", 64'(bus.instret_o), 64'((i >= 5) ? i - 4 : 0));
      tick();
    end

    // Load-use on a full pipe.
    drive(1'b1, '0, 1'b1, 1'b0, 1'b0);
    chk("lu_en_lit",  64'(bus.stg_en_o),  64'(5'b11100));
    chk("lu_clr_lit", 64'(bus.stg_clr_o), 64'(5'b00100));
    saved = bus.stall_cnt_o;
    tick();
    drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
    chk("lu_bubble_lit", 64'(bus.stg_vld_o), 64'(5'b11011));
    chk("lu_stall_lit",  64'(bus.stall_cnt_o), 64'(saved + 1));
    tick();

    // Taken branch together with load-use: flush wins.
    drive(1'b1, '0, 1'b1, 1'b1, 1'b0);
    chk("br_flush_lit", 64'(bus.flush_o),   64'd1);
    chk("br_en_lit",    64'(bus.stg_en_o),  64'(5'b11111));
    chk("br_clr_lit",   64'(bus.stg_clr_o), 64'(5'b00110));
    saved = bus.stall_cnt_o;
    tick();
    drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
    chk("br_vld_lit",   64'(bus.stg_vld_o[2:1]), 64'd0);
    chk("br_stall_lit", 64'(bus.stall_cnt_o), 64'(saved));
    tick();
    for (int i = 0; i < 5; i++) step(1'b1, '0, 1'b0, 1'b0, 1'b0);

    // Hold in stage 3 for three cycles with a taken branch pending behind it.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'b01000, 1'b0, 1'b1, 1'b0);
      chk("hold_en_lit",    64'(bus.stg_en_o),  64'(5'b10000));
      chk("hold_clr_lit",   64'(bus.stg_clr_o), 64'(5'b10000));
      chk("hold_flush_lit", 64'(bus.flush_o),   64'd0);
      chk("hold_ret_lit",   64'(bus.retire_o),  64'(i == 0));
      tick();
    end
    for (int i = 0; i < 6; i++) step(1'b1, '0, 1'b0, 1'b0, 1'b0);

    // Counter clear coinciding with a retire, then 16 retires wrap the 4-bit counter.
    drive(1'b1, '0, 1'b0, 1'b0, 1'b1);
    chk("clr_ret_lit", 64'(bus.retire_o), 64'd1);
    tick();
    for (int j = 0; j <= 16; j++) begin
      drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
      if (j == 0)  chk("clr_inst_lit", 64'(bus.instret_o), 64'd0);
      if (j == 16) begin
        chk("wrap_inst32_lit", 64'(bus.instret_o),  64'd16);
        chk("wrap_inst4_lit",  64'(bus4.instret_o), 64'd0);
      end
      tick();
    end

    // Async reset in the middle of a hold with the pipe full.
    drive(1'b1, 5'b10000, 1'b0, 1'b0, 1'b0);
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_vld_lit",   64'(bus.stg_vld_o[4:1]), 64'd0);
    chk("arst_inst_lit",  64'(bus.instret_o),      64'd0);
    chk("arst_stall_lit", 64'(bus.stall_cnt_o),    64'd0);
    chk("arst_ret_lit",   64'(bus.retire_o),       64'd0);
    model_reset();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;

    // Random hazards.
    for (int i = 0; i < 3000; i++) begin
      logic [NS-1:0] rh;
      for (int k = 0; k < NS; k++) rh[k] = ($urandom_range(0, 99) < 8);
      step($urandom_range(0, 99) < 80, rh, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
